// File: rtl/uart_apb_sequencer_if.sv
// uart_apb_sequencer_if: APB3 signal bundle between the UART sequencer
// (master) and the UART register block on the cfg bus (slave).
interface uart_apb_sequencer_if #(
    parameter int unsigned AddressWidth = 20,
    parameter int unsigned DataWidth    = 32
);
    logic                    presetn;
    logic [AddressWidth-1:0] paddr;
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic                    pready;
    logic [DataWidth-1:0]    prdata;
    logic                    pslverr;

    modport master (
        output presetn, paddr, pselx, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  presetn, paddr, pselx, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB3 requester serialising UART register traffic.
// Each service reads STATUS, then issues at most one DATA read (RX) or one
// DATA write (TX); RX and TX alternate when both are possible.
// Optional feature macro: UART_SEQ_TIMEOUT_EN (ACCESS-phase wait limit).
module uart_apb_sequencer #(
    parameter int unsigned               AddressWidth  = 20,
    parameter int unsigned               DataWidth     = 32,
    parameter logic [AddressWidth-1:0]   StatusAddr    = 'h0,
    parameter logic [AddressWidth-1:0]   DataAddr      = 'h4,
    parameter int unsigned               PollDiv       = 1024,
    parameter int unsigned               TimeoutCycles = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_apb_sequencer_if.master        apb,
    input  logic                        tx_valid,
    input  logic [7:0]                  tx_data,
    output logic                        tx_ready,
    output logic                        rx_valid,
    output logic [7:0]                  rx_data,
    output logic                        err_o
);
    localparam int unsigned PollW = (PollDiv > 2) ? $clog2(PollDiv) : 1;

    if (PollDiv < 2) begin : g_bad_polldiv
        $error("PollDiv must be at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
    typedef enum logic [1:0] {OP_STAT, OP_RXRD, OP_TXWR} op_t;

    state_t            state, state_n;
    op_t               op, op_n;
    logic              rr_last_tx, rr_tx_n;
    logic [7:0]        tx_byte, tx_byte_n;
    logic [PollW-1:0]  poll_cnt;
    logic              poll_wrap, poll_pending;
    logic              stat_start, tx_ready_n, rx_valid_n, err_n;
    logic              rx_avail, tx_ok;
    logic              timeout;

    assign apb.presetn = rst_n;
    assign poll_wrap   = (poll_cnt == PollW'(PollDiv - 1));

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
    logic [WaitW-1:0] wait_cnt;

    // Count consecutive ACCESS cycles with pready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != S_ACCESS || apb.pready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (state == S_ACCESS) && !apb.pready &&
                     (wait_cnt == WaitW'(TimeoutCycles - 1));
`else
    assign timeout = 1'b0;
`endif

    // Free-running poll divider; a tick that lands during a busy transfer
    // stays pending until the next STATUS SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            if (poll_wrap) begin
                poll_pending <= 1'b1;
            end else if (stat_start) begin
                poll_pending <= 1'b0;
            end
        end
    end

    // FSM state, current op, round-robin memory and latched TX byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op         <= OP_STAT;
            rr_last_tx <= 1'b1;
            tx_byte    <= '0;
        end else begin
            state      <= state_n;
            op         <= op_n;
            rr_last_tx <= rr_tx_n;
            tx_byte    <= tx_byte_n;
        end
    end

    // Registered completion pulses and received byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            err_o    <= 1'b0;
            rx_data  <= '0;
        end else begin
            tx_ready <= tx_ready_n;
            rx_valid <= rx_valid_n;
            err_o    <= err_n;
            if (rx_valid_n) begin
                rx_data <= apb.prdata[7:0];
            end
        end
    end

    // Next-state logic: STATUS result chains straight into the data SETUP.
    always_comb begin
        state_n    = state;
        op_n       = op;
        rr_tx_n    = rr_last_tx;
        tx_byte_n  = tx_byte;
        stat_start = 1'b0;
        tx_ready_n = 1'b0;
        rx_valid_n = 1'b0;
        err_n      = 1'b0;
        rx_avail   = apb.prdata[0];
        tx_ok      = tx_valid & ~apb.prdata[1];
        case (state)
            S_IDLE: begin
                if (tx_valid || poll_pending) begin
                    state_n    = S_SETUP;
                    op_n       = OP_STAT;
                    stat_start = 1'b1;
                end
            end
            S_SETUP: state_n = S_ACCESS;
            S_ACCESS: begin
                if (timeout) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else if (apb.pready) begin
                    state_n = S_IDLE;
                    err_n   = apb.pslverr;
                    case (op)
                        OP_STAT: begin
                            if (!apb.pslverr) begin
                                if (rx_avail && tx_ok) begin
                                    state_n = S_SETUP;
                                    if (rr_last_tx) begin
                                        op_n    = OP_RXRD;
                                        rr_tx_n = 1'b0;
                                    end else begin
                                        op_n      = OP_TXWR;
                                        rr_tx_n   = 1'b1;
                                        tx_byte_n = tx_data;
                                    end
                                end else if (rx_avail) begin
                                    state_n = S_SETUP;
                                    op_n    = OP_RXRD;
                                end else if (tx_ok) begin
                                    state_n   = S_SETUP;
                                    op_n      = OP_TXWR;
                                    tx_byte_n = tx_data;
                                end
                            end
                        end
                        OP_RXRD: rx_valid_n = ~apb.pslverr;
                        OP_TXWR: tx_ready_n = tx_valid;
                        default: ;
                    endcase
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // APB outputs decoded from state/op; everything is zero in S_IDLE.
    always_comb begin
        apb.pselx   = (state != S_IDLE);
        apb.penable = (state == S_ACCESS);
        apb.paddr   = '0;
        apb.pwrite  = 1'b0;
        apb.pwdata  = '0;
        if (state != S_IDLE) begin
            apb.paddr  = (op == OP_STAT) ? StatusAddr : DataAddr;
            apb.pwrite = (op == OP_TXWR);
            if (op == OP_TXWR) begin
                apb.pwdata = {{(DataWidth-8){1'b0}}, tx_byte};
            end
        end
    end
endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: directed self-checking bench with a simple UART
// register slave (programmable STATUS/DATA, stall and error injection).
module tb_uart_apb_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready, rx_valid, err_o;
    logic [7:0]  rx_data;

    logic [31:0] status_val, data_val;
    logic        stall, err_all, err_data;

    int checks = 0;
    int errors = 0;

    uart_apb_sequencer_if #(.AddressWidth(20), .DataWidth(32)) apb ();

    uart_apb_sequencer #(
        .AddressWidth (20),
        .DataWidth    (32),
        .StatusAddr   (20'h0),
        .DataAddr     (20'h4),
        .PollDiv      (64),
        .TimeoutCycles(256)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .apb      (apb),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    // UART register slave model
    always_comb begin
        apb.pready  = ~stall;
        apb.prdata  = (apb.paddr == 20'h4) ? data_val : status_val;
        apb.pslverr = apb.pselx && apb.penable &&
                      (err_all || (err_data && apb.paddr == 20'h4));
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_setup(input logic [19:0] addr, input int maxc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (apb.pselx && !apb.penable && apb.paddr == addr) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_psel"},  {31'b0, apb.pselx},   32'h0);
        check({tag, "_pen"},   {31'b0, apb.penable}, 32'h0);
        check({tag, "_paddr"}, {12'b0, apb.paddr},   32'h0);
        check({tag, "_pwr"},   {31'b0, apb.pwrite},  32'h0);
        check({tag, "_pwd"},   apb.pwdata,           32'h0);
        check({tag, "_txr"},   {31'b0, tx_ready},    32'h0);
    endtask

    initial begin
        bit          found;
        int          n;
        bit          hold;
        logic [31:0] wr_seq;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
        status_val = '0; data_val = '0;
        stall = 1'b0; err_all = 1'b0; err_data = 1'b0;

        // Reset state
        #1;
        check_idle_outputs("rst");
        check("rst_rxv",  {31'b0, rx_valid}, 32'h0);
        check("rst_rxd",  {24'b0, rx_data},  32'h0);
        check("rst_err",  {31'b0, err_o},    32'h0);
        check("rst_pres", {31'b0, apb.presetn}, 32'h0);
        do_reset();
        check("pres_hi",  {31'b0, apb.presetn}, 32'h1);

        // T1: zero-wait TX, STATUS=0
        tx_valid = 1'b1; tx_data = 8'h62;
        tick();
        check("t1_stat_setup", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b100, 29'h0});
        tick();
        check("t1_stat_acc", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b110, 29'h0});
        tick();
        check("t1_tx_setup", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b101, 29'h4});
        check("t1_pwdata", apb.pwdata, 32'h62);
        tick();
        check("t1_tx_acc", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b111, 29'h4});
        check("t1_txr_early", {31'b0, tx_ready}, 32'h0);
        tick();
        check("t1_txr", {31'b0, tx_ready}, 32'h1);
        check("t1_idle", {31'b0, apb.pselx}, 32'h0);
        tx_valid = 1'b0;
        tick();
        check("t1_txr_pulse", {31'b0, tx_ready}, 32'h0);

        // T2: poll-driven RX, STATUS=1, DATA=0x41
        do_reset();
        status_val = 32'h1; data_val = 32'h41;
        wait_setup(20'h0, 200, found);
        check("t2_poll_seen", {31'b0, found}, 32'h1);
        tick();
        check("t2_stat_acc", {apb.pselx, apb.penable, 10'b0, apb.paddr}, {2'b11, 30'h0});
        tick();
        check("t2_rx_setup", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b100, 29'h4});
        tick();
        check("t2_rx_acc", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b110, 29'h4});
        tick();
        check("t2_rxv", {31'b0, rx_valid}, 32'h1);
        check("t2_rxd", {24'b0, rx_data}, 32'h41);
        check("t2_idle", {31'b0, apb.pselx}, 32'h0);
        tick();
        check("t2_rxv_pulse", {31'b0, rx_valid}, 32'h0);
        check("t2_rxd_hold", {24'b0, rx_data}, 32'h41);

        // Poll period: STAT-only services every PollDiv cycles
        status_val = 32'h0;
        wait_setup(20'h0, 200, found);
        check("poll2_seen", {31'b0, found}, 32'h1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(apb.pselx && !apb.penable) && n < 200);
        check("poll_period", n, 32'd64);

        // T3: STATUS=3 with TX pending -> RX only, TX after STATUS=0
        do_reset();
        status_val = 32'h3; data_val = 32'h55;
        tx_valid = 1'b1; tx_data = 8'h77;
        tick(); tick(); tick();
        check("t3_rd_not_wr", {apb.pselx, apb.penable, apb.pwrite, 9'b0, apb.paddr}, {3'b100, 29'h4});
        tick(); tick();
        check("t3_rxv", {31'b0, rx_valid}, 32'h1);
        check("t3_rxd", {24'b0, rx_data},  32'h55);
        check("t3_no_txr", {31'b0, tx_ready}, 32'h0);
        status_val = 32'h0;
        tick();
        check("t3_restat", {apb.pselx, apb.penable, 10'b0, apb.paddr}, {2'b10, 30'h0});
        tick(); tick();
        check("t3_tx_setup", {apb.pselx, apb.pwrite, apb.pwdata[29:0]}, {2'b11, 30'h77});
        check("t3_rxd_hold", {24'b0, rx_data}, 32'h55);
        tick(); tick();
        check("t3_txr", {31'b0, tx_ready}, 32'h1);
        tx_valid = 1'b0;

        // T4: round-robin RX, TX, RX, TX
        do_reset();
        status_val = 32'h1; data_val = 32'h41;
        tx_valid = 1'b1; tx_data = 8'h10;
        wr_seq = '0;
        for (int k = 0; k < 4; k++) begin
            wait_setup(20'h4, 20, found);
            check("t4_data_seen", {31'b0, found}, 32'h1);
            wr_seq[k] = apb.pwrite;
            tick();
        end
        check("t4_rr_order", wr_seq, 32'b1010);
        tx_valid = 1'b0;

        // T5: pready held low on STATUS
        do_reset();
        stall = 1'b1; tx_valid = 1'b1; tx_data = 8'h01; status_val = 32'h0;
        tick();
        tick();
        hold = 1'b1;
`ifdef UART_SEQ_TIMEOUT_EN
        for (int k = 0; k < 255; k++) begin
            hold &= apb.pselx & apb.penable & ~err_o;
            tick();
        end
        hold &= apb.pselx & apb.penable & ~err_o;
        check("t5_wait_hold", {31'b0, hold}, 32'h1);
        tick();
        check("t5_tmo_err", {31'b0, err_o}, 32'h1);
        check("t5_tmo_idle", {apb.pselx, apb.penable, tx_ready, rx_valid}, 4'b0000);
        tx_valid = 1'b0; stall = 1'b0;
        tick();
        check("t5_err_pulse", {31'b0, err_o}, 32'h0);
`else
        for (int k = 0; k < 300; k++) begin
            hold &= apb.pselx & apb.penable & ~err_o;
            tick();
        end
        check("t5_wait_hold", {31'b0, hold}, 32'h1);
        tx_valid = 1'b0; stall = 1'b0;
        tick();
        check("t5_release_idle", {apb.pselx, err_o, tx_ready}, 3'b000);
`endif

        // T6: reset mid TX ACCESS, then slave error on STATUS
        do_reset();
        status_val = 32'h0; tx_valid = 1'b1; tx_data = 8'h99;
        tick(); tick(); tick(); tick();
        check("t6_tx_acc", {apb.penable, apb.pwrite}, 2'b11);
        rst_n = 1'b0; err_all = 1'b1;
        #1;
        check_idle_outputs("t6_abort");
        tick();
        check("t6_no_txr", {31'b0, tx_ready}, 32'h0);
        rst_n = 1'b1;
        tick(); tick();
        check("t6_stat_acc", {apb.pselx, apb.penable, 10'b0, apb.paddr}, {2'b11, 30'h0});
        tick();
        check("t6_err", {31'b0, err_o}, 32'h1);
        check("t6_no_dataop", {apb.pselx, tx_ready, rx_valid}, 3'b000);
        tx_valid = 1'b0; err_all = 1'b0;
        tick();
        check("t6_single_err", {apb.pselx, err_o}, 2'b00);

        // T7: slave error on TX DATA write drops the byte but acks
        do_reset();
        status_val = 32'h0; err_data = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        tick(); tick(); tick(); tick(); tick();
        check("t7_txr_err", {30'b0, tx_ready, err_o}, 32'h3);
        tx_valid = 1'b0; err_data = 1'b0;

        // T8: slave error on RX DATA read suppresses rx_valid
        do_reset();
        status_val = 32'h3; data_val = 32'hAA; err_data = 1'b1; tx_valid = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check("t8_rx_err", {29'b0, rx_valid, err_o, tx_ready}, 32'h2);
        check("t8_rxd_kept", {24'b0, rx_data}, 32'h0);
        tx_valid = 1'b0; err_data = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
